// File: rtl/beep_sequencer_pkg.sv
// Shared constants for the beep sequencer: FSM encoding, request mode codes,
// output amplitudes and a width helper used to size the counters.
package beep_pkg;

  // FSM state encoding (kept as plain constants so older tools can read it)
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_TONE = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  // Request mode codes
  localparam logic MODE_CONT  = 1'b0;
  localparam logic MODE_PULSE = 1'b1;

  // Square-wave amplitudes selected by amp_sel
  localparam logic [11:0] AMP_HALF = 12'h400;
  localparam logic [11:0] AMP_FULL = 12'h800;

  // Bits needed to hold values 0..v-1, never less than one bit
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  // Larger of two integers, used for the shared half-period counter
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/beep_sequencer_if.sv
// Request/status bundle between the keypad logic (master) and the beep
// sequencer (slave), plus read-only debug taps of the sequencer internals.
//
// Handshake: start is a single-cycle request strobe that is only looked at
// while the sequencer is idle; it is accepted when abort is low and num is in
// range, busy rises the next cycle and stays high until the sequencer is idle
// again. done pulses for exactly one cycle on normal completion (never after
// abort or reset). A start presented while busy is dropped, not queued.
interface beep_sequencer_if #(
  parameter int DATA_W = 12,
  parameter int NUM_W  = 4
);

  logic              start;
  logic              abort;
  logic [NUM_W-1:0]  num;
  logic              mode;
  logic              pitch_sel;
  logic              amp_sel;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] audio_out;
  logic [1:0]        state_dbg;
  logic              phase_dbg;

  modport master (
    output start, abort, num, mode, pitch_sel, amp_sel,
    input  busy, done, audio_out, state_dbg, phase_dbg
  );

  modport slave (
    input  start, abort, num, mode, pitch_sel, amp_sel,
    output busy, done, audio_out, state_dbg, phase_dbg
  );

endinterface

// File: rtl/beep_sequencer_tone_divider.sv
// Square-wave phase generator. A clear forces phase high with the counter at
// zero, so the first cycle after a clear always starts a high half period.
// While enabled the counter runs 0..half_cyc-1 and phase flips at the top.
// phase_nxt exposes the value phase will take at the next edge so the parent
// can register its output in step with the phase flop.
module tone_divider #(
  parameter int HALF_W = 19
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              en,
  input  logic [HALF_W-1:0] half_cyc,
  output logic              phase,
  output logic              phase_nxt
);

  logic [HALF_W-1:0] cnt_q, cnt_d;
  logic              phase_q, phase_d;
  logic [HALF_W-1:0] half_last;

  assign half_last = half_cyc - HALF_W'(1);

  // Next counter/phase: clear wins over counting
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (clear) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (en) begin
      if (cnt_q == half_last) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + HALF_W'(1);
      end
    end
  end

  // Counter and phase registers
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase     = phase_q;
  assign phase_nxt = phase_d;

endmodule

// File: rtl/beep_sequencer.sv
// Beep/tone sequencer feeding 12-bit square-wave samples to the DAC path.
// A request plays either one continuous tone of (num+1) units or (num+1)
// one-unit beeps separated by silent gaps. Pitch and amplitude are latched
// with the request; abort ends a request early without a done pulse.
module beep_sequencer
  import beep_pkg::*;
#(
  parameter int DATA_W      = 12,
  parameter int NUM_W       = 4,
  parameter int MAX_UNITS   = 10,
  parameter int UNIT_CYC    = 10_000_000,
  parameter int GAP_CYC     = 5_000_000,
  parameter int HALF_LO_CYC = 263_158,
  parameter int HALF_HI_CYC = 131_579
) (
  input  logic             clock,
  input  logic             reset,
  beep_sequencer_if.slave  bus
);

  // Counter widths: tone length up to UNIT_CYC*MAX_UNITS cycles, gap up to
  // GAP_CYC cycles, half period must hold the HALF_* value itself.
  localparam int DUR_W  = clog2_min1(UNIT_CYC * MAX_UNITS);
  localparam int GAP_W  = clog2_min1(GAP_CYC);
  localparam int HALF_W = clog2_min1(max_int(HALF_LO_CYC, HALF_HI_CYC) + 1);

  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYC - 1);
  localparam logic [DUR_W-1:0]  UNIT_LAST = DUR_W'(UNIT_CYC - 1);
  localparam logic [HALF_W-1:0] HALF_LO = HALF_W'(HALF_LO_CYC);
  localparam logic [HALF_W-1:0] HALF_HI = HALF_W'(HALF_HI_CYC);

  // FSM and counters
  logic [1:0]        state_q, state_d;
  logic [DUR_W-1:0]  dur_q, dur_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [NUM_W-1:0]  beep_q, beep_d;

  // Latched request fields
  logic [NUM_W-1:0]  num_q, num_d;
  logic              mode_q, mode_d;
  logic              pitch_q, pitch_d;
  logic              amp_q, amp_d;

  // Registered outputs
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] audio_q, audio_d;

  // Divider control and taps
  logic              div_clear;
  logic              div_en;
  logic              phase;
  logic              phase_nxt;
  logic [HALF_W-1:0] half_cyc;

  // Derived request decode
  logic              req_ok;
  logic              accept;
  logic [DUR_W-1:0]  tone_last;
  logic [DATA_W-1:0] amp_val;

  // A start is only honoured in IDLE, with abort low and num in range
  assign req_ok = (32'(bus.num) < 32'(MAX_UNITS));
  assign accept = (state_q == ST_IDLE) && bus.start && !bus.abort && req_ok;

  // Last cycle index of the current TONE: one unit per beep in pulse mode,
  // (num+1) units for a continuous tone.
  assign tone_last = (mode_q == MODE_PULSE)
                   ? UNIT_LAST
                   : DUR_W'(UNIT_CYC * (32'(num_q) + 32'd1) - 32'd1);

  assign half_cyc = pitch_q ? HALF_HI : HALF_LO;
  assign div_en   = (state_q == ST_TONE);

  tone_divider #(
    .HALF_W (HALF_W)
  ) u_div (
    .clock     (clock),
    .reset     (reset),
    .clear     (div_clear),
    .en        (div_en),
    .half_cyc  (half_cyc),
    .phase     (phase),
    .phase_nxt (phase_nxt)
  );

  // FSM next state, counters, request latching and done generation
  always_comb begin
    state_d   = state_q;
    dur_d     = dur_q;
    gap_d     = gap_q;
    beep_d    = beep_q;
    num_d     = num_q;
    mode_d    = mode_q;
    pitch_d   = pitch_q;
    amp_d     = amp_q;
    done_d    = 1'b0;
    div_clear = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          num_d     = bus.num;
          mode_d    = bus.mode;
          pitch_d   = bus.pitch_sel;
          amp_d     = bus.amp_sel;
          dur_d     = '0;
          gap_d     = '0;
          beep_d    = '0;
          div_clear = 1'b1;
          state_d   = ST_TONE;
        end
      end

      ST_TONE: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (dur_q == tone_last) begin
          if (mode_q == MODE_CONT) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else if (beep_q == num_q) begin
            // Last beep: finish without a trailing gap
            beep_d  = beep_q + NUM_W'(1);
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            beep_d  = beep_q + NUM_W'(1);
            gap_d   = '0;
            state_d = ST_GAP;
          end
        end else begin
          dur_d = dur_q + DUR_W'(1);
        end
      end

      ST_GAP: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (gap_q == GAP_LAST) begin
          // Each beep restarts the square wave on a high half period
          dur_d     = '0;
          div_clear = 1'b1;
          state_d   = ST_TONE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Amplitude of the request that will be active next cycle
  assign amp_val = amp_d ? DATA_W'(AMP_FULL) : DATA_W'(AMP_HALF);

  // Output next values, derived from next state so outputs are registered
  // yet line up with the state they describe.
  always_comb begin
    busy_d  = (state_d != ST_IDLE);
    audio_d = '0;
    if ((state_d == ST_TONE) && phase_nxt) begin
      audio_d = amp_val;
    end
  end

  // State, counters, latches and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      dur_q   <= '0;
      gap_q   <= '0;
      beep_q  <= '0;
      num_q   <= '0;
      mode_q  <= 1'b0;
      pitch_q <= 1'b0;
      amp_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      audio_q <= '0;
    end else begin
      state_q <= state_d;
      dur_q   <= dur_d;
      gap_q   <= gap_d;
      beep_q  <= beep_d;
      num_q   <= num_d;
      mode_q  <= mode_d;
      pitch_q <= pitch_d;
      amp_q   <= amp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      audio_q <= audio_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.audio_out = audio_q;
  assign bus.state_dbg = state_q;
  assign bus.phase_dbg = phase;

endmodule

// File: tb/tb_beep_sequencer.sv
// Directed bench for beep_sequencer with short time constants.
module tb_beep_sequencer;
  import beep_pkg::*;

  localparam int UNIT = 20;
  localparam int GAP  = 8;
  localparam int HLO  = 4;
  localparam int HHI  = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [11:0] exp_q[$];
  logic [11:0] exp_v;

  beep_sequencer_if #(.DATA_W(12), .NUM_W(4)) bus ();

  beep_sequencer #(
    .DATA_W      (12),
    .NUM_W       (4),
    .MAX_UNITS   (10),
    .UNIT_CYC    (UNIT),
    .GAP_CYC     (GAP),
    .HALF_LO_CYC (HLO),
    .HALF_HI_CYC (HHI)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Clock and reset timing
  always #5 clock = ~clock;

  // Advance to just after the next active edge
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.num       = 4'd0;
    bus.mode      = 1'b0;
    bus.pitch_sel = 1'b0;
    bus.amp_sel   = 1'b0;
  endtask

  task automatic drive_req(input logic [3:0] n, input logic m,
                           input logic p, input logic a);
    bus.num       = n;
    bus.mode      = m;
    bus.pitch_sel = p;
    bus.amp_sel   = a;
    bus.start     = 1'b1;
  endtask

  // Expected samples of one tone: high half first, toggling every half cycles
  task automatic push_tone(input int len, input int half, input logic [11:0] amp);
    for (int t = 0; t < len; t++) begin
      exp_q.push_back((((t / half) % 2) == 0) ? amp : 12'h000);
    end
  endtask

  task automatic push_silence(input int len);
    for (int t = 0; t < len; t++) exp_q.push_back(12'h000);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (3) step();
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b exp 0", bus.done); end
    n_cmp++; if (bus.audio_out !== 12'h000) begin n_bad++; $display("FAIL reset_audio got %h exp 000", bus.audio_out); end
    n_cmp++; if (bus.state_dbg !== ST_IDLE) begin n_bad++; $display("FAIL reset_state got %0d exp %0d", bus.state_dbg, ST_IDLE); end
    reset = 1'b0;
    step();
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL post_reset_busy got %b exp 0", bus.busy); end
  endtask

  task automatic test_cont();
    exp_q.delete();
    push_tone(3 * UNIT, HLO, 12'h800);
    drive_req(4'd2, MODE_CONT, 1'b0, 1'b1);
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 3 * UNIT; k++) begin
      exp_v = exp_q.pop_front();
      n_cmp++; if (bus.audio_out !== exp_v) begin n_bad++; $display("FAIL cont_audio k=%0d got %h exp %h", k, bus.audio_out, exp_v); end
      n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL cont_busy k=%0d got %b exp 1", k, bus.busy); end
      n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL cont_done_early k=%0d got %b exp 0", k, bus.done); end
      // A start sampled on the completion edge must be ignored
      if (k == 3 * UNIT - 1) drive_req(4'd1, MODE_CONT, 1'b0, 1'b1);
      step();
    end
    bus.start = 1'b0;
    n_cmp++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL cont_done got %b exp 1", bus.done); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL cont_end_busy got %b exp 0", bus.busy); end
    n_cmp++; if (bus.audio_out !== 12'h000) begin n_bad++; $display("FAIL cont_end_audio got %h exp 000", bus.audio_out); end
    step();
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL cont_done_width got %b exp 0", bus.done); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL cont_late_start_busy got %b exp 0", bus.busy); end
  endtask

  task automatic test_pulse();
    exp_q.delete();
    push_tone(UNIT, HHI, 12'h400);
    push_silence(GAP);
    push_tone(UNIT, HHI, 12'h400);
    drive_req(4'd1, MODE_PULSE, 1'b1, 1'b0);
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 2 * UNIT + GAP; k++) begin
      exp_v = exp_q.pop_front();
      n_cmp++; if (bus.audio_out !== exp_v) begin n_bad++; $display("FAIL pulse_audio k=%0d got %h exp %h", k, bus.audio_out, exp_v); end
      n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL pulse_busy k=%0d got %b exp 1", k, bus.busy); end
      n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL pulse_done_early k=%0d got %b exp 0", k, bus.done); end
      step();
    end
    n_cmp++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL pulse_done got %b exp 1", bus.done); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL pulse_end_busy got %b exp 0", bus.busy); end
    n_cmp++; if (bus.audio_out !== 12'h000) begin n_bad++; $display("FAIL pulse_end_audio got %h exp 000", bus.audio_out); end
    step();
    n_cmp++; if (bus.state_dbg !== ST_IDLE) begin n_bad++; $display("FAIL pulse_no_trailing_gap got %0d exp %0d", bus.state_dbg, ST_IDLE); end
  endtask

  task automatic test_reject();
    logic [3:0] bad_num[2];
    bad_num[0] = 4'hF;
    bad_num[1] = 4'd10;
    for (int i = 0; i < 2; i++) begin
      drive_req(bad_num[i], MODE_CONT, 1'b0, 1'b1);
      step();
      bus.start = 1'b0;
      for (int c = 0; c < 3; c++) begin
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reject_busy num=%0d got %b exp 0", bad_num[i], bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reject_done num=%0d got %b exp 0", bad_num[i], bus.done); end
        n_cmp++; if (bus.audio_out !== 12'h000) begin n_bad++; $display("FAIL reject_audio num=%0d got %h exp 000", bad_num[i], bus.audio_out); end
        step();
      end
    end
    // abort in IDLE beats a simultaneous start
    drive_req(4'd0, MODE_CONT, 1'b0, 1'b1);
    bus.abort = 1'b1;
    step();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL abort_beats_start got %b exp 0", bus.busy); end
    // num = MAX_UNITS-1 is the largest legal request
    drive_req(4'd9, MODE_CONT, 1'b0, 1'b1);
    step();
    bus.start = 1'b0;
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL accept_num9 got %b exp 1", bus.busy); end
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL num9_abort_busy got %b exp 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL num9_abort_done got %b exp 0", bus.done); end
  endtask

  task automatic test_abort();
    drive_req(4'd3, MODE_CONT, 1'b0, 1'b1);
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      exp_v = (((k / HLO) % 2) == 0) ? 12'h800 : 12'h000;
      n_cmp++; if (bus.audio_out !== exp_v) begin n_bad++; $display("FAIL abort_pre_audio k=%0d got %h exp %h", k, bus.audio_out, exp_v); end
      if (k == 9) bus.abort = 1'b1;
      step();
    end
    bus.abort = 1'b0;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got %b exp 0", bus.busy); end
    n_cmp++; if (bus.audio_out !== 12'h000) begin n_bad++; $display("FAIL abort_audio got %h exp 000", bus.audio_out); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL abort_done got %b exp 0", bus.done); end
    n_cmp++; if (bus.state_dbg !== ST_IDLE) begin n_bad++; $display("FAIL abort_state got %0d exp %0d", bus.state_dbg, ST_IDLE); end
    // New request right after the abort: one unit, high pitch, half amplitude
    drive_req(4'd0, MODE_CONT, 1'b1, 1'b0);
    step();
    bus.start = 1'b0;
    for (int k = 0; k < UNIT; k++) begin
      exp_v = (((k / HHI) % 2) == 0) ? 12'h400 : 12'h000;
      n_cmp++; if (bus.audio_out !== exp_v) begin n_bad++; $display("FAIL restart_audio k=%0d got %h exp %h", k, bus.audio_out, exp_v); end
      n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL restart_busy k=%0d got %b exp 1", k, bus.busy); end
      step();
    end
    n_cmp++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL restart_done got %b exp 1", bus.done); end
    step();
  endtask

  task automatic test_back_to_back();
    drive_req(4'd1, MODE_PULSE, 1'b0, 1'b1);
    step();
    bus.start = 1'b0;
    for (int k = 0; k < UNIT + 4; k++) begin
      exp_v = (k < UNIT && (((k / HLO) % 2) == 0)) ? 12'h800 : 12'h000;
      n_cmp++; if (bus.audio_out !== exp_v) begin n_bad++; $display("FAIL b2b_audio k=%0d got %h exp %h", k, bus.audio_out, exp_v); end
      n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL b2b_busy k=%0d got %b exp 1", k, bus.busy); end
      // Mid-request start with different fields must be dropped
      if (k == 5) drive_req(4'd5, MODE_CONT, 1'b1, 1'b0);
      if (k == 6) bus.start = 1'b0;
      if (k == UNIT + 3) begin
        n_cmp++; if (bus.state_dbg !== ST_GAP) begin n_bad++; $display("FAIL b2b_in_gap got %0d exp %0d", bus.state_dbg, ST_GAP); end
        reset = 1'b1;
      end
      step();
    end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL midgap_reset_busy got %b exp 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL midgap_reset_done got %b exp 0", bus.done); end
    n_cmp++; if (bus.audio_out !== 12'h000) begin n_bad++; $display("FAIL midgap_reset_audio got %h exp 000", bus.audio_out); end
    n_cmp++; if (bus.state_dbg !== ST_IDLE) begin n_bad++; $display("FAIL midgap_reset_state got %0d exp %0d", bus.state_dbg, ST_IDLE); end
    reset = 1'b0;
    idle_inputs();
    step();
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL post_reset_done got %b exp 0", bus.done); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL post_reset_idle got %b exp 0", bus.busy); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_cont();
    test_pulse();
    test_reject();
    test_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
